// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank: FSM states, R/W encoding
// and the frame-length helper.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    OVER = 2'd3
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Frame is R/W bit, then address, then data, MSB first.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_LEN  = frame_len(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by a previous-value
// flop so that single-cycle rise and fall pulses can be produced.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits with
// validated write commit on chip-select release and read-back over CIPO.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int CMD_BITS   = 1 + ADDR_W;
  localparam int FRAME_BITS = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0]  CNT_CMD    = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_rise;
  logic sclk_fall;
  logic ncs_rise;
  logic ncs_fall;
  logic copi_meta_q;
  logic copi_sync_q;

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [CMD_BITS-1:0] cmd_next;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                cipo_oe_q, cipo_oe_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic                frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W-1:0]   snap_addr;
  logic [DATA_W-1:0]   rd_word;
  logic                is_write;
  logic                addr_ok;
  logic                commit_ok;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ncs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (nCS),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copi_meta_q <= 1'b0;
      copi_sync_q <= 1'b0;
    end else begin
      copi_meta_q <= COPI;
      copi_sync_q <= copi_meta_q;
    end
  end

  assign cmd_next  = (cmd_q << 1) | CMD_BITS'(copi_sync_q);
  assign cmd_addr  = cmd_q[ADDR_W-1:0];
  assign snap_addr = cmd_next[ADDR_W-1:0];
  assign is_write  = (cmd_q[ADDR_W] == RW_WRITE);
  assign addr_ok   = ({1'b0, cmd_addr} < NUM_REGS_W);
  assign commit_ok = (state_q == DATA) && is_write && (cnt_q == CNT_FULL) && addr_ok;

  // Out-of-range addresses match no register and so snapshot as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (snap_addr == ADDR_W'(k)) rd_word = regs_q[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    cipo_oe_d   = cipo_oe_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    if (ncs_rise) begin
      // Chip-select release wins over any SCLK edge seen in the same cycle.
      if (state_q != IDLE) begin
        if (commit_ok) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr == ADDR_W'(k)) regs_d[k] = shift_q;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = cmd_addr;
        end else if ((state_q != DATA) || is_write) begin
          frame_err_d = 1'b1;
        end
      end
      state_d   = IDLE;
      cnt_d     = '0;
      cmd_d     = '0;
      shift_d   = '0;
      tx_d      = '0;
      cipo_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_ONE;
            cmd_d = cmd_next;
            if (cnt_d == CNT_CMD) begin
              state_d = DATA;
              if (cmd_next[ADDR_W] == RW_READ) begin
                tx_d      = rd_word;
                cipo_oe_d = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            if (cnt_q == CNT_FULL) begin
              state_d = OVER;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
              if (is_write) shift_d = (shift_q << 1) | DATA_W'(copi_sync_q);
            end
          end else if (sclk_fall && !is_write && (cnt_q > CNT_CMD)) begin
            // The fall right after the address keeps the MSB on CIPO for the first sample.
            tx_d = tx_q << 1;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign CIPO      = tx_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: two instances (8x8 and 4x16) share SCLK/COPI with
// separate chip selects; a frame model feeds an expectation queue.
module tb_spi_reg_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic copi  = 1'b0;
  logic ncs_a = 1'b1;
  logic ncs_b = 1'b1;

  logic        cipo_a, oe_a, strobe_a, err_a;
  logic [63:0] flat_a;
  logic [6:0]  waddr_a;
  logic        cipo_b, oe_b, strobe_b, err_b;
  logic [63:0] flat_b;
  logic [6:0]  waddr_b;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(7)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs_a),
    .CIPO(cipo_a), .cipo_oe(oe_a), .regs_flat(flat_a),
    .wr_strobe(strobe_a), .wr_addr(waddr_a), .frame_err(err_a)
  );

  spi_reg_bank #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(7)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs_b),
    .CIPO(cipo_b), .cipo_oe(oe_b), .regs_flat(flat_b),
    .wr_strobe(strobe_b), .wr_addr(waddr_b), .frame_err(err_b)
  );

  // Pulse monitors count high cycles, so a stretched pulse shows up as 2.
  int strobe_cyc [2];
  int err_cyc    [2];
  initial begin
    strobe_cyc[0] = 0; strobe_cyc[1] = 0; err_cyc[0] = 0; err_cyc[1] = 0;
  end
  always @(negedge clk) begin
    if (strobe_a === 1'b1) strobe_cyc[0]++;
    if (strobe_b === 1'b1) strobe_cyc[1]++;
    if (err_a === 1'b1) err_cyc[0]++;
    if (err_b === 1'b1) err_cyc[1]++;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  string       exp_tag_q [$];
  logic [63:0] exp_val_q [$];

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    string       t;
    logic [63:0] v;
    if (exp_val_q.size() == 0) begin
      chk("scoreboard_underflow", got, 64'bx);
    end else begin
      t = exp_tag_q.pop_front();
      v = exp_val_q.pop_front();
      chk(t, got, v);
    end
  endtask

  logic [15:0] m_regs  [2][8];
  logic [6:0]  m_waddr [2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_waddr[s] = '0;
      for (int k = 0; k < 8; k++) m_regs[s][k] = '0;
    end
  endtask

  function automatic logic [63:0] model_flat(input int sel);
    logic [63:0] f;
    f = '0;
    if (sel == 0) begin
      for (int k = 0; k < 8; k++) f[k*8 +: 8] = m_regs[0][k][7:0];
    end else begin
      for (int k = 0; k < 4; k++) f[k*16 +: 16] = m_regs[1][k];
    end
    return f;
  endfunction

  function automatic logic [31:0] mk(input bit rw, input int addr, input int data, input int dw);
    logic [31:0] w;
    w = (32'(rw) << (7 + dw)) | (32'(addr & 'h7f) << dw) | (32'(data) & ((32'd1 << dw) - 32'd1));
    return w;
  endfunction

  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) ncs_a = v;
    else ncs_b = v;
  endtask

  // Mode-0 controller: COPI set on fall, CIPO sampled just before each rise.
  task automatic spi_xfer(input int sel, input int nbits, input logic [31:0] word,
                          input bit hold_cs, output logic [31:0] rd, output int oe_hits);
    logic c;
    logic o;
    rd = '0;
    oe_hits = 0;
    set_cs(sel, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = word[nbits-1-i];
      repeat (6) @(negedge clk);
      if (i >= 8) begin
        c = (sel == 0) ? cipo_a : cipo_b;
        o = (sel == 0) ? oe_a : oe_b;
        rd = (rd << 1) | 32'(c);
        if (o === 1'b1) oe_hits++;
      end
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
    copi = 1'b0;
    if (!hold_cs) begin
      repeat (6) @(negedge clk);
      set_cs(sel, 1'b1);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic frame(input int sel, input int nbits, input logic [31:0] word);
    int          fl, dw, nr, s0, e0, oe_hits;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] data, exp_rd, mask;
    bit          exp_commit, exp_err, exp_read;
    logic [31:0] rd;
    fl = (sel == 0) ? 16 : 24;
    dw = (sel == 0) ? 8 : 16;
    nr = (sel == 0) ? 8 : 4;
    mask = (sel == 0) ? 16'h00ff : 16'hffff;
    exp_commit = 0; exp_err = 0; exp_read = 0;
    rw = 1'b0; addr = '0; exp_rd = '0;
    data = word[15:0] & mask;
    if (nbits < 8 || nbits > fl) begin
      exp_err = 1;
    end else begin
      rw   = word[nbits-1];
      addr = 7'(word >> (nbits - 8));
      if (rw) begin
        if (nbits == fl && int'(addr) < nr) exp_commit = 1;
        else exp_err = 1;
      end else if (nbits == fl) begin
        exp_read = 1;
        if (int'(addr) < nr) exp_rd = m_regs[sel][int'(addr)];
      end
    end
    if (exp_commit) begin
      m_regs[sel][int'(addr)] = data;
      m_waddr[sel] = addr;
    end
    sb_push("wr_strobe_cycles", 64'(exp_commit));
    sb_push("frame_err_cycles", 64'(exp_err));
    if (exp_read) begin
      sb_push("read_data", 64'(exp_rd));
      sb_push("read_oe_samples", 64'(dw));
    end
    sb_push("regs_flat", model_flat(sel));
    sb_push("wr_addr", 64'(m_waddr[sel]));
    sb_push("cipo_oe_idle", 64'd0);
    sb_push("cipo_idle", 64'd0);

    s0 = strobe_cyc[sel];
    e0 = err_cyc[sel];
    spi_xfer(sel, nbits, word, 1'b0, rd, oe_hits);
    $display("frame dut%0d bits=%0d word=0x%0h rw=%0d addr=%0d read=0x%0h strobes=%0d errs=%0d",
             sel, nbits, word, rw, addr, rd[15:0] & mask,
             strobe_cyc[sel] - s0, err_cyc[sel] - e0);

    sb_pop(64'(strobe_cyc[sel] - s0));
    sb_pop(64'(err_cyc[sel] - e0));
    if (exp_read) begin
      sb_pop(64'(rd[15:0] & mask));
      sb_pop(64'(oe_hits));
    end
    sb_pop((sel == 0) ? flat_a : flat_b);
    sb_pop(64'((sel == 0) ? waddr_a : waddr_b));
    sb_pop(64'((sel == 0) ? oe_a : oe_b));
    sb_pop(64'((sel == 0) ? cipo_a : cipo_b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_unused;
    int          oe_unused, s0, e0, a, d;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_regs8", flat_a, 64'd0);
    chk("rst_regs16", flat_b, 64'd0);
    chk("rst_cipo", 64'(cipo_a), 64'd0);
    chk("rst_oe", 64'(oe_a), 64'd0);
    chk("rst_strobe", 64'(strobe_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_waddr", 64'(waddr_a), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) frame(0, 16, mk(0, i, 'hff, 8));

    frame(0, 16, mk(1, 3, 'hA5, 8));
    frame(0, 16, mk(0, 3, 0, 8));
    frame(0, 16, mk(1, 9, 'h55, 8));
    frame(0, 16, mk(0, 9, 0, 8));
    frame(0, 12, mk(1, 1, 'h77, 8) >> 4);
    frame(0, 18, (mk(1, 1, 'h77, 8) << 2) | 32'd3);
    frame(0, 20, mk(0, 3, 0, 8) << 4);
    frame(0, 5, mk(1, 2, 'h11, 8) >> 11);

    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(7));
      d = int'($urandom_range(255));
      frame(0, 16, mk(1, a, d, 8));
      frame(0, 16, mk(0, a, 0, 8));
    end

    // Reset in the middle of a write: everything returns to zero, no pulses.
    s0 = strobe_cyc[0];
    e0 = err_cyc[0];
    spi_xfer(0, 10, mk(1, 5, 'hC3, 8) >> 6, 1'b1, rd_unused, oe_unused);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    ncs_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("reset mid-frame applied, regs8=0x%0h", flat_a);
    chk("midrst_regs8", flat_a, model_flat(0));
    chk("midrst_regs16", flat_b, model_flat(1));
    chk("midrst_strobe_cycles", 64'(strobe_cyc[0] - s0), 64'd0);
    chk("midrst_err_cycles", 64'(err_cyc[0] - e0), 64'd0);

    frame(0, 16, mk(1, 0, 'h3C, 8));
    frame(0, 16, mk(0, 0, 0, 8));
    frame(0, 16, mk(0, 1, 0, 8));

    frame(1, 24, mk(1, 2, 'hBEEF, 16));
    frame(1, 24, mk(0, 2, 0, 16));
    frame(1, 24, mk(1, 5, 'h1234, 16));
    frame(1, 24, mk(0, 7, 0, 16));
    frame(1, 20, mk(1, 1, 'hCAFE, 16) >> 4);
    frame(1, 24, mk(1, 0, 'h8001, 16));
    frame(1, 24, mk(0, 0, 0, 16));
    chk("dut8_untouched", flat_a, model_flat(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
